// File: rtl/stream_arb_mux_if.sv
// -----------------------------------------------------------------------------
// stream_arb_mux_if
//   Bundle of stream signals around stream_arb_mux.
//   Channel side : valid_i / ready_o / words_i / last_i (one lane per input)
//   Sink side    : valid_o / ready_i / word_o / last_o / sel_o
//   modport slave  - the multiplexer itself
//   modport master - whatever drives the producers and the sink (e.g. a bench)
// -----------------------------------------------------------------------------
interface stream_arb_mux_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int INPUT_COUNT = 4,
  parameter int ADDR_WIDTH  = 2
);
  localparam int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT;

  logic [INPUT_COUNT-1:0] valid_i;
  logic [INPUT_COUNT-1:0] ready_o;
  logic [TOTAL_WIDTH-1:0] words_i;
  logic [INPUT_COUNT-1:0] last_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [WORD_WIDTH-1:0]  word_o;
  logic                   last_o;
  logic [ADDR_WIDTH-1:0]  sel_o;

  modport slave (
    input  valid_i, words_i, last_i, ready_i,
    output ready_o, valid_o, word_o, last_o, sel_o
  );

  modport master (
    output valid_i, words_i, last_i, ready_i,
    input  ready_o, valid_o, word_o, last_o, sel_o
  );
endinterface

// File: rtl/stream_arb_mux.sv
// -----------------------------------------------------------------------------
// stream_arb_mux
//   N:1 stream multiplexer with per-channel valid/ready, built-in arbitration
//   (fixed priority or round-robin) and packet locking. The output stage is a
//   single register: 1-cycle latency, one beat per cycle.
//
//   clk_i  - clock, rising edge
//   rst_i  - synchronous reset, active-high
//   bus    - stream_arb_mux_if.slave (channel inputs, registered output)
//
//   Once a channel delivers a beat without last, it owns the output until its
//   last beat; bubbles on that channel stall everyone else.
// -----------------------------------------------------------------------------
module stream_arb_mux #(
  parameter int WORD_WIDTH  = 8,
  parameter int INPUT_COUNT = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int ARB_MODE    = 0,
  parameter int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  stream_arb_mux_if.slave  bus
);

  typedef enum logic {
    ST_OPEN,    // free arbitration
    ST_LOCKED   // mid-packet: only grant_q may be served
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                   valid_q, valid_d;
  logic [WORD_WIDTH-1:0]  word_q, word_d;
  logic                   last_q, last_d;
  logic [ADDR_WIDTH-1:0]  sel_q, sel_d;

  logic [TOTAL_WIDTH-1:0] words;
  logic                   load;
  logic                   arb_found;
  logic [ADDR_WIDTH-1:0]  arb_idx;
  logic                   have_sel;
  logic [ADDR_WIDTH-1:0]  sel_idx;
  logic [WORD_WIDTH-1:0]  word_sel;
  logic                   last_sel;
  logic [INPUT_COUNT-1:0] ready;
  logic                   xfer;

  assign words = bus.words_i;

  // The output register can take a new word when empty or being drained.
  // This is a combinational path from ready_i to ready_o.
  assign load = !valid_q || bus.ready_i;

  // Arbitration. In round-robin mode the first pass only looks at channels at
  // or above rr_ptr; the second pass covers the wrap-around part. In fixed
  // priority mode only the second pass is active, so lowest index wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    arb_found = 1'b0;
    arb_idx   = '0;
    if (ARB_MODE == 1) begin
      for (int k = 0; k < INPUT_COUNT; k++) begin
        if (!arb_found && bus.valid_i[k] && (ADDR_WIDTH'(k) >= rr_ptr_q)) begin
          arb_found = 1'b1;
          arb_idx   = ADDR_WIDTH'(k);
        end
      end
    end
    for (int k = 0; k < INPUT_COUNT; k++) begin
      if (!arb_found && bus.valid_i[k]) begin
        arb_found = 1'b1;
        arb_idx   = ADDR_WIDTH'(k);
      end
    end
  end

  // While locked the granted channel is selected even if it is not valid,
  // which is what makes a bubble stall the other channels.
  assign have_sel = (state_q == ST_LOCKED) || arb_found;
  assign sel_idx  = (state_q == ST_LOCKED) ? grant_q : arb_idx;

  always_comb begin
    word_sel = '0;
    last_sel = 1'b0;
    ready    = '0;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      if (sel_idx == ADDR_WIDTH'(k)) begin
        word_sel = words[k*WORD_WIDTH +: WORD_WIDTH];
        last_sel = bus.last_i[k];
        ready[k] = load && have_sel && !rst_i;
      end
    end
  end

  assign xfer = |(bus.valid_i & ready);

  // Next-state logic for the lock FSM and the output register.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    valid_d  = valid_q;
    word_d   = word_q;
    last_d   = last_q;
    sel_d    = sel_q;
    if (xfer) begin
      valid_d = 1'b1;
      word_d  = word_sel;
      last_d  = last_sel;
      sel_d   = sel_idx;
      if (!last_sel) begin
        state_d = ST_LOCKED;
        grant_d = sel_idx;
      end else begin
        state_d = ST_OPEN;
        // The pointer moves only on packet completion, never mid-packet.
        if (ARB_MODE == 1) begin
          rr_ptr_d = (sel_idx == ADDR_WIDTH'(INPUT_COUNT - 1)) ? '0
                                                               : sel_idx + 1'b1;
        end
      end
    end else if (valid_q && bus.ready_i) begin
      // Drained with nothing to replace it; data/last/sel keep their values.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      // NOTE: the lock clears immediately on reset; a partially emitted
      // packet is left for upstream to deal with.
      state_q  <= ST_OPEN;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      word_q   <= '0;
      last_q   <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      word_q   <= word_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.word_o  = word_q;
  assign bus.last_o  = last_q;
  assign bus.sel_o   = sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_stream_arb_mux
//   Directed bench for stream_arb_mux. Three instances:
//     dut_fp : 4 inputs, fixed priority
//     dut_rr : 4 inputs, round-robin
//     dut_r3 : 3 inputs, round-robin (non-power-of-two wrap)
//   Each step drives one instance (the others see idle inputs), checks the
//   combinational ready_o before the edge and the registered outputs after.
// -----------------------------------------------------------------------------
module tb_stream_arb_mux;

  localparam int DUT_FP = 0;
  localparam int DUT_RR = 1;
  localparam int DUT_R3 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_arb_mux_if #(.WORD_WIDTH(8), .INPUT_COUNT(4), .ADDR_WIDTH(2)) bus_fp ();
  stream_arb_mux_if #(.WORD_WIDTH(8), .INPUT_COUNT(4), .ADDR_WIDTH(2)) bus_rr ();
  stream_arb_mux_if #(.WORD_WIDTH(8), .INPUT_COUNT(3), .ADDR_WIDTH(2)) bus_r3 ();

  stream_arb_mux #(.WORD_WIDTH(8), .INPUT_COUNT(4), .ADDR_WIDTH(2), .ARB_MODE(0))
    dut_fp (.clk_i(clk), .rst_i(rst), .bus(bus_fp));
  stream_arb_mux #(.WORD_WIDTH(8), .INPUT_COUNT(4), .ADDR_WIDTH(2), .ARB_MODE(1))
    dut_rr (.clk_i(clk), .rst_i(rst), .bus(bus_rr));
  stream_arb_mux #(.WORD_WIDTH(8), .INPUT_COUNT(3), .ADDR_WIDTH(2), .ARB_MODE(1))
    dut_r3 (.clk_i(clk), .rst_i(rst), .bus(bus_r3));

  typedef struct {
    string       name;
    int          dut;
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] words;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_word;
    logic        exp_last;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  logic [3:0] act_ready;
  logic       act_valid;
  logic [7:0] act_word;
  logic       act_last;
  logic [1:0] act_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input int d, input logic r, input logic [3:0] v,
                     input logic [3:0] l, input logic [31:0] w, input logic rdy,
                     input logic [3:0] er, input logic ev, input logic [7:0] ew,
                     input logic el, input logic [1:0] es);
    vec_t t;
    t.name = n; t.dut = d; t.rst = r; t.valid = v; t.last = l; t.words = w;
    t.rdy = rdy; t.exp_ready = er; t.exp_valid = ev; t.exp_word = ew;
    t.exp_last = el; t.exp_sel = es;
    vecs.push_back(t);
  endtask

  task automatic drive(input int d, input logic r, input logic [3:0] v,
                       input logic [3:0] l, input logic [31:0] w, input logic rdy);
    rst = r;
    bus_fp.valid_i = (d == DUT_FP) ? v   : 4'b0;
    bus_fp.last_i  = (d == DUT_FP) ? l   : 4'b0;
    bus_fp.words_i = (d == DUT_FP) ? w   : 32'b0;
    bus_fp.ready_i = (d == DUT_FP) ? rdy : 1'b0;
    bus_rr.valid_i = (d == DUT_RR) ? v   : 4'b0;
    bus_rr.last_i  = (d == DUT_RR) ? l   : 4'b0;
    bus_rr.words_i = (d == DUT_RR) ? w   : 32'b0;
    bus_rr.ready_i = (d == DUT_RR) ? rdy : 1'b0;
    bus_r3.valid_i = (d == DUT_R3) ? v[2:0]  : 3'b0;
    bus_r3.last_i  = (d == DUT_R3) ? l[2:0]  : 3'b0;
    bus_r3.words_i = (d == DUT_R3) ? w[23:0] : 24'b0;
    bus_r3.ready_i = (d == DUT_R3) ? rdy : 1'b0;
  endtask

  task automatic sample(input int d);
    case (d)
      DUT_FP: begin
        act_ready = bus_fp.ready_o; act_valid = bus_fp.valid_o;
        act_word = bus_fp.word_o; act_last = bus_fp.last_o; act_sel = bus_fp.sel_o;
      end
      DUT_RR: begin
        act_ready = bus_rr.ready_o; act_valid = bus_rr.valid_o;
        act_word = bus_rr.word_o; act_last = bus_rr.last_o; act_sel = bus_rr.sel_o;
      end
      default: begin
        act_ready = {1'b0, bus_r3.ready_o}; act_valid = bus_r3.valid_o;
        act_word = bus_r3.word_o; act_last = bus_r3.last_o; act_sel = bus_r3.sel_o;
      end
    endcase
  endtask

  // Called 1 time unit after a rising edge: drive, check ready_o, clock,
  // check the registered outputs 1 time unit after the next edge.
  task automatic step(input string n, input int d, input logic r, input logic [3:0] v,
                      input logic [3:0] l, input logic [31:0] w, input logic rdy,
                      input logic [3:0] er, input logic ev, input logic [7:0] ew,
                      input logic el, input logic [1:0] es);
    drive(d, r, v, l, w, rdy);
    #1;
    sample(d);
    check({n, " ready_o"}, 32'(act_ready), 32'(er));
    @(posedge clk);
    #1;
    sample(d);
    check({n, " valid_o"}, 32'(act_valid), 32'(ev));
    check({n, " word_o"},  32'(act_word),  32'(ew));
    check({n, " last_o"},  32'(act_last),  32'(el));
    check({n, " sel_o"},   32'(act_sel),   32'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- vector table ----------------
    // Reset with everything valid, then release: ch0 first in both modes.
    add("fp_rst0",  DUT_FP, 1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'h00, 0, 2'd0);
    add("fp_rst1",  DUT_FP, 1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'h00, 0, 2'd0);
    add("fp_rel",   DUT_FP, 0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 1, 2'd0);
    // Fixed priority: ch1 beats ch3 every cycle.
    for (int i = 0; i < 3; i++)
      add("fp_prio", DUT_FP, 0, 4'b1010, 4'b1111, 32'h33001100, 1, 4'b0010, 1, 8'h11, 1, 2'd1);
    // Packet lock on ch2 with a bubble; ch0 keeps asking.
    add("lk_c0",    DUT_FP, 0, 4'b0100, 4'b0000, 32'h00C00000, 1, 4'b0100, 1, 8'hC0, 0, 2'd2);
    add("lk_bub",   DUT_FP, 0, 4'b0001, 4'b0001, 32'h00000055, 1, 4'b0100, 0, 8'hC0, 0, 2'd2);
    add("lk_c1",    DUT_FP, 0, 4'b0101, 4'b0001, 32'h00C10055, 1, 4'b0100, 1, 8'hC1, 0, 2'd2);
    add("lk_c2",    DUT_FP, 0, 4'b0101, 4'b0101, 32'h00C20055, 1, 4'b0100, 1, 8'hC2, 1, 2'd2);
    add("lk_ch0",   DUT_FP, 0, 4'b0101, 4'b0101, 32'h00000055, 1, 4'b0001, 1, 8'h55, 1, 2'd0);
    // Round-robin, four inputs.
    add("rr_rst0",  DUT_RR, 1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'h00, 0, 2'd0);
    add("rr_rst1",  DUT_RR, 1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 0, 8'h00, 0, 2'd0);
    add("rr_s0",    DUT_RR, 0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 1, 2'd0);
    add("rr_s1",    DUT_RR, 0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0010, 1, 8'hA1, 1, 2'd1);
    add("rr_s2",    DUT_RR, 0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0100, 1, 8'hA2, 1, 2'd2);
    add("rr_s3",    DUT_RR, 0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b1000, 1, 8'hA3, 1, 2'd3);
    add("rr_s4",    DUT_RR, 0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 1, 2'd0);
    add("rr_s5",    DUT_RR, 0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0010, 1, 8'hA1, 1, 2'd1);
    // Two-beat packet on ch2: the pointer moves only after its last beat.
    add("rr_pk0",   DUT_RR, 0, 4'b1111, 4'b1011, 32'hA3A2A1A0, 1, 4'b0100, 1, 8'hA2, 0, 2'd2);
    add("rr_pk1",   DUT_RR, 0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0100, 1, 8'hA2, 1, 2'd2);
    add("rr_pk2",   DUT_RR, 0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b1000, 1, 8'hA3, 1, 2'd3);
    // Three inputs: pointer wraps from 2 back to 0.
    add("r3_rst",   DUT_R3, 1, 4'b0111, 4'b0111, 32'h00B2B1B0, 1, 4'b0000, 0, 8'h00, 0, 2'd0);
    add("r3_s0",    DUT_R3, 0, 4'b0111, 4'b0111, 32'h00B2B1B0, 1, 4'b0001, 1, 8'hB0, 1, 2'd0);
    add("r3_s1",    DUT_R3, 0, 4'b0111, 4'b0111, 32'h00B2B1B0, 1, 4'b0010, 1, 8'hB1, 1, 2'd1);
    add("r3_s2",    DUT_R3, 0, 4'b0111, 4'b0111, 32'h00B2B1B0, 1, 4'b0100, 1, 8'hB2, 1, 2'd2);
    add("r3_s3",    DUT_R3, 0, 4'b0111, 4'b0111, 32'h00B2B1B0, 1, 4'b0001, 1, 8'hB0, 1, 2'd0);
    add("r3_s4",    DUT_R3, 0, 4'b0111, 4'b0111, 32'h00B2B1B0, 1, 4'b0010, 1, 8'hB1, 1, 2'd1);

    drive(DUT_FP, 1'b1, 4'b0, 4'b0, 32'b0, 1'b0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].dut, vecs[i].rst,
           vecs[i].valid, vecs[i].last, vecs[i].words, vecs[i].rdy,
           vecs[i].exp_ready, vecs[i].exp_valid, vecs[i].exp_word,
           vecs[i].exp_last, vecs[i].exp_sel);
    end

    // ---------------- backpressure ----------------
    // Load 0x42, stall three cycles with ch1 waiting, then release and drain.
    step("bp_load",  DUT_FP, 0, 4'b0001, 4'b0001, 32'h00000042, 1, 4'b0001, 1, 8'h42, 1, 2'd0);
    for (int i = 0; i < 3; i++)
      step($sformatf("bp_hold%0d", i), DUT_FP, 0, 4'b0010, 4'b0010, 32'h00004300, 0,
           4'b0000, 1, 8'h42, 1, 2'd0);
    step("bp_rel",   DUT_FP, 0, 4'b0010, 4'b0010, 32'h00004300, 1, 4'b0010, 1, 8'h43, 1, 2'd1);
    step("bp_drain", DUT_FP, 0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h43, 1, 2'd1);

    // ---------------- reset mid-packet ----------------
    // ch1 opens a packet; reset must drop the lock so ch0 wins afterwards.
    step("mr_beat",  DUT_RR, 1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'h00, 0, 2'd0);
    step("mr_open",  DUT_RR, 0, 4'b0010, 4'b0000, 32'h0000D100, 1, 4'b0010, 1, 8'hD1, 0, 2'd1);
    step("mr_rst",   DUT_RR, 1, 4'b0011, 4'b0001, 32'h0000D250, 1, 4'b0000, 0, 8'h00, 0, 2'd0);
    step("mr_after", DUT_RR, 0, 4'b0011, 4'b0001, 32'h0000D250, 1, 4'b0001, 1, 8'h50, 1, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
